// File: rtl/lat_unit_scoreboard.sv
// Scoreboard for destination registers of in-flight multi-cycle ops on the
// MDU, AMO and FPU. Each unit holds at most one op. A done pulse starts a short
// settle window so that ID keeps stalling while the result reaches forwarding.
module lat_unit_scoreboard #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned NUM_UNITS     = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 issue_valid,
  input  logic [1:0]           issue_unit,
  input  logic [4:0]           issue_rd,
  input  logic                 issue_fp,
  input  logic                 mdu_done,
  input  logic                 amo_done,
  input  logic                 fpu_done,
  input  logic                 id_valid,
  input  logic [4:0]           id_rs1,
  input  logic [4:0]           id_rs2,
  input  logic [4:0]           id_fp_rs1,
  input  logic [4:0]           id_fp_rs2,
  input  logic [4:0]           id_fp_rs3,
  input  logic [4:0]           id_rd,
  input  logic                 id_rd_fp,
  output logic [NUM_UNITS-1:0] issue_ready,
  output logic                 stall_raw,
  output logic                 stall_waw,
  output logic [31:0]          int_busy_vec,
  output logic [31:0]          fp_busy_vec,
  output logic                 err_sticky
);

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] SETTLE_LOAD =
    (SETTLE_CYCLES == 0) ? CNT_W'(0) : CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXEC   = 2'd1,
    S_SETTLE = 2'd2
  } slot_state_e;

  slot_state_e            state_q [NUM_UNITS];
  slot_state_e            state_d [NUM_UNITS];
  logic [4:0]             rd_q    [NUM_UNITS];
  logic [4:0]             rd_d    [NUM_UNITS];
  logic                   fp_q    [NUM_UNITS];
  logic                   fp_d    [NUM_UNITS];
  logic [CNT_W-1:0]       cnt_q   [NUM_UNITS];
  logic [CNT_W-1:0]       cnt_d   [NUM_UNITS];
  logic                   err_d;

  logic [NUM_UNITS-1:0]   done;
  logic [NUM_UNITS-1:0]   issue_sel;
  logic [NUM_UNITS-1:0]   idle;
  logic [NUM_UNITS-1:0]   exec;

  assign done = NUM_UNITS'({fpu_done, amo_done, mdu_done});

  // Decode per-slot issue targets and current slot phase.
  always_comb begin
    issue_sel = '0;
    idle      = '0;
    exec      = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      issue_sel[u] = issue_valid && (issue_unit == 2'(u));
      idle[u]      = (state_q[u] == S_IDLE);
      exec[u]      = (state_q[u] == S_EXEC);
    end
  end

  // Slot state registers and sticky protocol error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        state_q[u] <= S_IDLE;
        rd_q[u]    <= '0;
        fp_q[u]    <= 1'b0;
        cnt_q[u]   <= '0;
      end
      err_sticky <= 1'b0;
    end else begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        state_q[u] <= state_d[u];
        rd_q[u]    <= rd_d[u];
        fp_q[u]    <= fp_d[u];
        cnt_q[u]   <= cnt_d[u];
      end
      err_sticky <= err_d;
    end
  end

  // Next-state logic per slot; flush wins over issue and done.
  always_comb begin
    for (int u = 0; u < NUM_UNITS; u++) begin
      state_d[u] = state_q[u];
      rd_d[u]    = rd_q[u];
      fp_d[u]    = fp_q[u];
      cnt_d[u]   = cnt_q[u];
      case (state_q[u])
        S_IDLE: begin
          if (issue_sel[u]) begin
            state_d[u] = S_EXEC;
            rd_d[u]    = issue_rd;
            fp_d[u]    = issue_fp;
          end
        end
        S_EXEC: begin
          if (done[u]) begin
            state_d[u] = (SETTLE_CYCLES == 0) ? S_IDLE : S_SETTLE;
            cnt_d[u]   = SETTLE_LOAD;
          end
        end
        S_SETTLE: begin
          if (cnt_q[u] == '0) state_d[u] = S_IDLE;
          else                cnt_d[u]   = cnt_q[u] - CNT_W'(1);
        end
        default: state_d[u] = S_IDLE;
      endcase
      if (flush) state_d[u] = S_IDLE;
    end
  end

  // Protocol violations are ignored by the slots but remembered until reset.
  always_comb begin
    err_d = err_sticky;
    if (!flush) begin
      if (issue_valid && (issue_unit == 2'd3)) err_d = 1'b1;
      if (|(issue_sel & ~idle))                err_d = 1'b1;
      if (|(done & ~exec))                     err_d = 1'b1;
    end
  end

  // Busy vectors and ready flags from registered slot state only.
  always_comb begin
    int_busy_vec = '0;
    fp_busy_vec  = '0;
    issue_ready  = idle;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (!idle[u]) begin
        if (fp_q[u])              fp_busy_vec[rd_q[u]]  = 1'b1;
        else if (rd_q[u] != 5'd0) int_busy_vec[rd_q[u]] = 1'b1;
      end
    end
  end

  // ID hazard checks against the pending destination sets.
  always_comb begin
    stall_raw = id_valid && (
                  ((id_rs1 != 5'd0) && int_busy_vec[id_rs1]) ||
                  ((id_rs2 != 5'd0) && int_busy_vec[id_rs2]) ||
                  fp_busy_vec[id_fp_rs1] ||
                  fp_busy_vec[id_fp_rs2] ||
                  fp_busy_vec[id_fp_rs3]);
    stall_waw = id_valid && (id_rd_fp ? fp_busy_vec[id_rd] : int_busy_vec[id_rd]);
  end

endmodule

// File: tb/tb_lat_unit_scoreboard.sv
// Directed bench for lat_unit_scoreboard with SETTLE_CYCLES=1.
module tb_lat_unit_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        issue_valid;
  logic [1:0]  issue_unit;
  logic [4:0]  issue_rd;
  logic        issue_fp;
  logic        mdu_done, amo_done, fpu_done;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_fp_rs1, id_fp_rs2, id_fp_rs3, id_rd;
  logic        id_rd_fp;
  logic [2:0]  issue_ready;
  logic        stall_raw, stall_waw, err_sticky;
  logic [31:0] int_busy_vec, fp_busy_vec;

  int n_checks = 0;
  int n_fail   = 0;

  lat_unit_scoreboard #(.SETTLE_CYCLES(1), .NUM_UNITS(3)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .issue_valid(issue_valid), .issue_unit(issue_unit), .issue_rd(issue_rd),
    .issue_fp(issue_fp), .mdu_done(mdu_done), .amo_done(amo_done),
    .fpu_done(fpu_done), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_fp_rs1(id_fp_rs1), .id_fp_rs2(id_fp_rs2), .id_fp_rs3(id_fp_rs3),
    .id_rd(id_rd), .id_rd_fp(id_rd_fp), .issue_ready(issue_ready),
    .stall_raw(stall_raw), .stall_waw(stall_waw), .int_busy_vec(int_busy_vec),
    .fp_busy_vec(fp_busy_vec), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs;
    flush = 0; issue_valid = 0; issue_unit = 0; issue_rd = 0; issue_fp = 0;
    mdu_done = 0; amo_done = 0; fpu_done = 0;
    id_valid = 0; id_rs1 = 0; id_rs2 = 0;
    id_fp_rs1 = 5'd31; id_fp_rs2 = 5'd31; id_fp_rs3 = 5'd31;
    id_rd = 0; id_rd_fp = 0;
  endtask

  // Advance one clock; inputs are changed 1ns after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
    #1;
  endtask

  task automatic issue(input logic [1:0] unit, input logic [4:0] rd, input logic fp);
    issue_valid = 1; issue_unit = unit; issue_rd = rd; issue_fp = fp;
    tick();
    issue_valid = 0;
    #1;
  endtask

  task automatic test_reset;
    do_reset();
    id_valid = 1;
    #1;
    n_checks++; if (issue_ready !== 3'b111) begin n_fail++; $display("FAIL reset_ready got %b want 111", issue_ready); end
    n_checks++; if (int_busy_vec !== 32'h0 || fp_busy_vec !== 32'h0) begin n_fail++; $display("FAIL reset_vec got %h/%h want 0/0", int_busy_vec, fp_busy_vec); end
    n_checks++; if (stall_raw !== 1'b0 || stall_waw !== 1'b0 || err_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_flags got raw=%b waw=%b err=%b want 0", stall_raw, stall_waw, err_sticky); end
  endtask

  task automatic test_raw_and_settle;
    do_reset();
    id_valid = 1; id_rs1 = 5'd5;
    issue_valid = 1; issue_unit = 2'd0; issue_rd = 5'd5; issue_fp = 0;
    #1;
    n_checks++; if (stall_raw !== 1'b0) begin n_fail++; $display("FAIL raw_issue_cycle got %b want 0", stall_raw); end
    tick();
    issue_valid = 0;
    #1;
    n_checks++; if (stall_raw !== 1'b1) begin n_fail++; $display("FAIL raw_next_cycle got %b want 1", stall_raw); end
    n_checks++; if (int_busy_vec !== 32'h20) begin n_fail++; $display("FAIL mdu_busy_vec got %h want 00000020", int_busy_vec); end
    n_checks++; if (issue_ready !== 3'b110) begin n_fail++; $display("FAIL mdu_ready got %b want 110", issue_ready); end
    tick();
    mdu_done = 1;
    #1;
    n_checks++; if (stall_raw !== 1'b1) begin n_fail++; $display("FAIL raw_done_cycle got %b want 1", stall_raw); end
    tick();
    mdu_done = 0;
    #1;
    n_checks++; if (stall_raw !== 1'b1 || issue_ready !== 3'b110) begin n_fail++; $display("FAIL settle_t1 got raw=%b ready=%b want 1/110", stall_raw, issue_ready); end
    tick();
    n_checks++; if (stall_raw !== 1'b0 || issue_ready !== 3'b111) begin n_fail++; $display("FAIL settle_t2 got raw=%b ready=%b want 0/111", stall_raw, issue_ready); end
    n_checks++; if (int_busy_vec !== 32'h0) begin n_fail++; $display("FAIL settle_vec got %h want 0", int_busy_vec); end
  endtask

  task automatic test_fp_and_x0;
    do_reset();
    issue(2'd2, 5'd0, 1'b1);
    id_valid = 1; id_fp_rs1 = 5'd1; id_fp_rs2 = 5'd2; id_fp_rs3 = 5'd0;
    #1;
    n_checks++; if (stall_raw !== 1'b1) begin n_fail++; $display("FAIL fp_rs3_raw got %b want 1", stall_raw); end
    n_checks++; if (fp_busy_vec !== 32'h1) begin n_fail++; $display("FAIL fp_vec got %h want 00000001", fp_busy_vec); end
    id_fp_rs3 = 5'd3;
    issue(2'd1, 5'd0, 1'b0);
    n_checks++; if (int_busy_vec !== 32'h0) begin n_fail++; $display("FAIL amo_x0_vec got %h want 0", int_busy_vec); end
    n_checks++; if (issue_ready !== 3'b001) begin n_fail++; $display("FAIL amo_x0_ready got %b want 001", issue_ready); end
    n_checks++; if (stall_raw !== 1'b0) begin n_fail++; $display("FAIL x0_no_raw got %b want 0", stall_raw); end
    amo_done = 1; fpu_done = 1;
    tick();
    amo_done = 0; fpu_done = 0;
    tick();
    n_checks++; if (issue_ready !== 3'b111 || fp_busy_vec !== 32'h0 || err_sticky !== 1'b0) begin n_fail++; $display("FAIL dual_done got ready=%b fp=%h err=%b want 111/0/0", issue_ready, fp_busy_vec, err_sticky); end
  endtask

  task automatic test_waw;
    do_reset();
    issue(2'd0, 5'd7, 1'b0);
    id_valid = 1; id_rd = 5'd7; id_rd_fp = 0;
    #1;
    n_checks++; if (stall_waw !== 1'b1) begin n_fail++; $display("FAIL waw_int got %b want 1", stall_waw); end
    id_rd_fp = 1;
    #1;
    n_checks++; if (stall_waw !== 1'b0) begin n_fail++; $display("FAIL waw_fp_file got %b want 0", stall_waw); end
    id_rd_fp = 0; id_valid = 0;
    #1;
    n_checks++; if (stall_waw !== 1'b0) begin n_fail++; $display("FAIL waw_no_valid got %b want 0", stall_waw); end
  endtask

  task automatic test_same_rd;
    do_reset();
    issue(2'd0, 5'd6, 1'b0);
    issue(2'd1, 5'd6, 1'b0);
    mdu_done = 1;
    tick();
    mdu_done = 0;
    tick();
    n_checks++; if (int_busy_vec !== 32'h40 || issue_ready !== 3'b101) begin n_fail++; $display("FAIL same_rd got vec=%h ready=%b want 00000040/101", int_busy_vec, issue_ready); end
  endtask

  task automatic test_flush;
    do_reset();
    issue(2'd0, 5'd3, 1'b0);
    issue(2'd1, 5'd4, 1'b0);
    issue(2'd2, 5'd9, 1'b1);
    n_checks++; if (int_busy_vec !== 32'h18 || fp_busy_vec !== 32'h200 || issue_ready !== 3'b000) begin n_fail++; $display("FAIL all_busy got int=%h fp=%h ready=%b want 18/200/000", int_busy_vec, fp_busy_vec, issue_ready); end
    flush = 1; issue_valid = 1; issue_unit = 2'd0; issue_rd = 5'd10; amo_done = 1;
    tick();
    idle_inputs();
    id_valid = 1; id_rs1 = 5'd3; id_rs2 = 5'd4; id_fp_rs1 = 5'd9;
    #1;
    n_checks++; if (issue_ready !== 3'b111 || int_busy_vec !== 32'h0 || fp_busy_vec !== 32'h0) begin n_fail++; $display("FAIL flush_state got ready=%b int=%h fp=%h want 111/0/0", issue_ready, int_busy_vec, fp_busy_vec); end
    n_checks++; if (err_sticky !== 1'b0 || stall_raw !== 1'b0) begin n_fail++; $display("FAIL flush_flags got err=%b raw=%b want 0/0", err_sticky, stall_raw); end
  endtask

  task automatic test_errors;
    do_reset();
    issue(2'd0, 5'd8, 1'b0);
    issue(2'd0, 5'd9, 1'b0);
    n_checks++; if (err_sticky !== 1'b1 || int_busy_vec !== 32'h100 || issue_ready !== 3'b110) begin n_fail++; $display("FAIL err_double_issue got err=%b vec=%h ready=%b want 1/00000100/110", err_sticky, int_busy_vec, issue_ready); end
    flush = 1;
    tick();
    flush = 0;
    #1;
    n_checks++; if (err_sticky !== 1'b1 || issue_ready !== 3'b111) begin n_fail++; $display("FAIL err_survives_flush got err=%b ready=%b want 1/111", err_sticky, issue_ready); end

    do_reset();
    amo_done = 1;
    tick();
    amo_done = 0;
    #1;
    n_checks++; if (err_sticky !== 1'b1 || issue_ready !== 3'b111) begin n_fail++; $display("FAIL err_stray_done got err=%b ready=%b want 1/111", err_sticky, issue_ready); end

    do_reset();
    issue(2'd3, 5'd12, 1'b0);
    n_checks++; if (err_sticky !== 1'b1 || issue_ready !== 3'b111 || int_busy_vec !== 32'h0) begin n_fail++; $display("FAIL err_unit3 got err=%b ready=%b vec=%h want 1/111/0", err_sticky, issue_ready, int_busy_vec); end
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    #12;
    test_reset();
    test_raw_and_settle();
    test_fp_and_x0();
    test_waw();
    test_same_rd();
    test_flush();
    test_errors();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
